// File: rtl/popcount28_tern_acc_if.sv
// Beat/result handshake bundle for popcount28_tern_acc.
// master = beat producer and result consumer; slave = the accumulator block.
interface popcount28_tern_acc_if #(
    parameter int ACC_W = 8
);
    logic [4:0]              pos_cnt;
    logic [4:0]              neg_cnt;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] thr_hi;
    logic signed [ACC_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_trit;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output pos_cnt, neg_cnt, in_valid, thr_hi, thr_lo, out_ready,
        input  in_ready, out_valid, out_trit, out_sum
    );

    modport slave (
        input  pos_cnt, neg_cnt, in_valid, thr_hi, thr_lo, out_ready,
        output in_ready, out_valid, out_trit, out_sum
    );
endinterface

// File: rtl/popcount28_tern_acc.sv
// Ternary neuron: accumulates NBEATS popcount deltas, thresholds into a trit.
// Define TERN_ACC_SAT_EN to saturate each accumulator update instead of wrapping.
module popcount28_tern_acc #(
    parameter int NBEATS = 4,
    parameter int ACC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    popcount28_tern_acc_if.slave    bus
);
    localparam int SUM_W = ACC_W + 2;
    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] out_sum_q;
    logic [1:0]              out_trit_q;
    logic                    beat_acc;
    logic                    last_beat;
    logic signed [SUM_W-1:0] delta_p0;
    logic signed [SUM_W-1:0] wide_p0;
    logic signed [ACC_W-1:0] sum_p0;

`ifdef TERN_ACC_SAT_EN
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(1 << (ACC_W - 1)));

    function automatic logic signed [ACC_W-1:0] acc_update(input logic signed [SUM_W-1:0] s);
        if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
        if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        return s[ACC_W-1:0];
    endfunction
`else
    // Plain two's-complement wrap: keep the low ACC_W bits.
    function automatic logic signed [ACC_W-1:0] acc_update(input logic signed [SUM_W-1:0] s);
        return s[ACC_W-1:0];
    endfunction
`endif

    // +1 wins over -1 when the threshold windows overlap.
    function automatic logic [1:0] tern_decide(input logic signed [ACC_W-1:0] s,
                                               input logic signed [ACC_W-1:0] hi,
                                               input logic signed [ACC_W-1:0] lo);
        if (s >= hi) return 2'b01;
        if (s <= lo) return 2'b11;
        return 2'b00;
    endfunction

    // Stage p0: combinational delta and next accumulator value
    always_comb begin
        delta_p0 = $signed({{(SUM_W-5){1'b0}}, bus.pos_cnt})
                 - $signed({{(SUM_W-5){1'b0}}, bus.neg_cnt});
        wide_p0  = $signed({{2{acc_q[ACC_W-1]}}, acc_q}) + delta_p0;
        sum_p0   = acc_update(wide_p0);
    end

    assign beat_acc  = bus.in_valid && (state_q == ST_ACC);
    assign last_beat = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && last_beat) state_d = ST_OUT;
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Stage p1: registered accumulator, counter and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_trit_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (beat_acc) begin
                if (last_beat) begin
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    out_sum_q  <= sum_p0;
                    out_trit_q <= tern_decide(sum_p0, bus.thr_hi, bus.thr_lo);
                end else begin
                    acc_q <= sum_p0;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_sum  = out_sum_q;
    assign bus.out_trit = out_trit_q;
endmodule

// File: tb/tb_popcount28_tern_acc.sv
// Self-checking bench for popcount28_tern_acc: default, ACC_W=6 and NBEATS=1 instances
// compared against an integer reference model.
module tb_popcount28_tern_acc;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    popcount28_tern_acc_if #(.ACC_W(8)) bus ();
    popcount28_tern_acc_if #(.ACC_W(6)) bus6 ();
    popcount28_tern_acc_if #(.ACC_W(8)) bus1 ();

    popcount28_tern_acc #(.NBEATS(4), .ACC_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    popcount28_tern_acc #(.NBEATS(4), .ACC_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
    popcount28_tern_acc #(.NBEATS(1), .ACC_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef TERN_ACC_SAT_EN
    localparam int W6_EXP = 31;
`else
    localparam int W6_EXP = -16;
`endif

    // Reference: one accumulator update of width w, saturating or wrapping.
    function automatic int upd(input int s, input int w);
`ifdef TERN_ACC_SAT_EN
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        int m = 1 << w;
        int r = s % m;
        if (r < 0) r += m;
        if (r >= (m / 2)) r -= m;
        return r;
`endif
    endfunction

    function automatic int model_sum(input int p[4], input int n[4], input int w);
        int acc = 0;
        for (int i = 0; i < 4; i++) acc = upd(acc + p[i] - n[i], w);
        return acc;
    endfunction

    function automatic logic [1:0] model_trit(input int s, input int hi, input int lo);
        if (s >= hi) return 2'b01;
        if (s <= lo) return 2'b11;
        return 2'b00;
    endfunction

    // Drives four beats on the default instance; reports whether out_valid rose exactly after the last.
    task automatic drive_beats(input int p[4], input int n[4], input bit gaps, output bit lat_ok);
        lat_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.pos_cnt  = 5'($urandom);
                    bus.neg_cnt  = 5'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.pos_cnt  = 5'(p[i]);
            bus.neg_cnt  = 5'(n[i]);
            bus.in_valid = 1'b1;
            begin
                int k = 0;
                while (!bus.in_ready && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                if (!bus.in_ready) begin
                    n_cmp++; n_err++;
                    $display("FAIL in_ready_timeout got=%0b exp=1", bus.in_ready);
                end
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid !== (i == 3)) lat_ok = 1'b0;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.pos_cnt = 5'd20; bus.neg_cnt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_sum !== 8'sd0) begin n_err++; $display("FAIL reset_out_sum got=%0d exp=0", bus.out_sum); end
        n_cmp++; if (bus.out_trit !== 2'b00) begin n_err++; $display("FAIL reset_out_trit got=%b exp=00", bus.out_trit); end
    endtask

    task automatic test_directed_sum();
        int p[4] = '{5, 4, 3, 2};
        int n[4] = '{1, 0, 2, 1};
        int got;
        bit lat;
        bus.thr_hi = 8'sd10; bus.thr_lo = -8'sd10;
        drive_beats(p, n, 1'b0, lat);
        got = bus.out_sum;
        n_cmp++; if (lat !== 1'b1) begin n_err++; $display("FAIL directed_latency got=%0b exp=1", lat); end
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL directed_sum got=%0d exp=10", got); end
        n_cmp++; if (bus.out_trit !== 2'b01) begin n_err++; $display("FAIL directed_trit got=%b exp=01", bus.out_trit); end
        consume();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL directed_release got=%0b%0b exp=01", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_negative_full();
        int p[4] = '{0, 0, 0, 0};
        int n[4] = '{28, 28, 28, 28};
        int got;
        bit lat;
        bus.thr_hi = 8'sd10; bus.thr_lo = -8'sd10;
        drive_beats(p, n, 1'b0, lat);
        got = bus.out_sum;
        n_cmp++; if (got != -112) begin n_err++; $display("FAIL neg_full_sum got=%0d exp=-112", got); end
        n_cmp++; if (bus.out_trit !== 2'b11) begin n_err++; $display("FAIL neg_full_trit got=%b exp=11", bus.out_trit); end
        consume();
    endtask

    task automatic test_backpressure();
        int p[4], n[4];
        int exp_s, got;
        bit lat;
        logic [1:0] exp_t;
        for (int i = 0; i < 4; i++) begin p[i] = $urandom_range(0, 28); n[i] = $urandom_range(0, 28); end
        bus.thr_hi = 8'sd5; bus.thr_lo = -8'sd5;
        exp_s = model_sum(p, n, 8);
        exp_t = model_trit(exp_s, 5, -5);
        drive_beats(p, n, 1'b0, lat);
        // A beat offered while the result is held must be ignored.
        bus.in_valid = 1'b1; bus.pos_cnt = 5'd17; bus.neg_cnt = 5'd0;
        for (int c = 0; c < 5; c++) begin
            got = bus.out_sum;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready c=%0d got=%0b exp=0", c, bus.in_ready); end
            n_cmp++; if (got != exp_s || bus.out_trit !== exp_t || bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL hold_stable c=%0d got=%0d/%b exp=%0d/%b", c, got, bus.out_trit, exp_s, exp_t);
            end
            @(posedge clk); #1;
        end
        consume();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_release got=%0b%0b exp=10", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin p[i] = $urandom_range(0, 28); n[i] = $urandom_range(0, 28); end
        exp_s = model_sum(p, n, 8);
        drive_beats(p, n, 1'b0, lat);
        got = bus.out_sum;
        n_cmp++; if (got != exp_s) begin n_err++; $display("FAIL after_hold_sum got=%0d exp=%0d", got, exp_s); end
        consume();
    endtask

    task automatic test_reset_mid();
        int p[4], n[4];
        int exp_s, got;
        bit lat;
        bus.thr_hi = 8'sd10; bus.thr_lo = -8'sd10;
        for (int i = 0; i < 2; i++) begin
            bus.pos_cnt = 5'd25; bus.neg_cnt = 5'd0; bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin p[i] = $urandom_range(0, 28); n[i] = $urandom_range(0, 28); end
        exp_s = model_sum(p, n, 8);
        drive_beats(p, n, 1'b0, lat);
        got = bus.out_sum;
        n_cmp++; if (got != exp_s || lat !== 1'b1) begin n_err++; $display("FAIL reset_mid_sum got=%0d exp=%0d", got, exp_s); end
        // Reset while a result is held clears it.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got = bus.out_sum;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_trit !== 2'b00 || got != 0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_hold got=%0b/%b/%0d exp=0/00/0", bus.out_valid, bus.out_trit, got);
        end
    endtask

    task automatic test_priority_and_gaps();
        int p[4] = '{3, 1, 0, 2};
        int n[4] = '{1, 3, 0, 2};
        int got;
        bit lat;
        bus.thr_hi = 8'sd0; bus.thr_lo = 8'sd0;
        drive_beats(p, n, 1'b1, lat);
        got = bus.out_sum;
        n_cmp++; if (got != 0) begin n_err++; $display("FAIL prio_sum got=%0d exp=0", got); end
        n_cmp++; if (bus.out_trit !== 2'b01) begin n_err++; $display("FAIL prio_trit got=%b exp=01", bus.out_trit); end
        consume();
    endtask

    task automatic test_random();
        int p[4], n[4];
        int exp_s, got, hi, lo;
        bit lat;
        logic [1:0] exp_t;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 4; i++) begin p[i] = $urandom_range(0, 31); n[i] = $urandom_range(0, 31); end
            hi = int'($urandom_range(0, 80)) - 40;
            lo = int'($urandom_range(0, 80)) - 40;
            bus.thr_hi = 8'(hi); bus.thr_lo = 8'(lo);
            exp_s = model_sum(p, n, 8);
            exp_t = model_trit(exp_s, hi, lo);
            drive_beats(p, n, 1'(t % 2), lat);
            got = bus.out_sum;
            n_cmp++; if (lat !== 1'b1) begin n_err++; $display("FAIL rand_latency t=%0d got=%0b exp=1", t, lat); end
            n_cmp++; if (got != exp_s || bus.out_trit !== exp_t) begin
                n_err++; $display("FAIL rand_result t=%0d got=%0d/%b exp=%0d/%b", t, got, bus.out_trit, exp_s, exp_t);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

    task automatic test_width6();
        int p[4], n[4];
        int exp_s, got, hi, lo;
        logic [1:0] exp_t;
        for (int t = 0; t < 11; t++) begin
            for (int i = 0; i < 4; i++) begin
                p[i] = (t == 0) ? 28 : int'($urandom_range(0, 31));
                n[i] = (t == 0) ? 0  : int'($urandom_range(0, 31));
            end
            hi = (t == 0) ? 10  : int'($urandom_range(0, 40)) - 20;
            lo = (t == 0) ? -10 : int'($urandom_range(0, 40)) - 20;
            bus6.thr_hi = 6'(hi); bus6.thr_lo = 6'(lo);
            exp_s = (t == 0) ? W6_EXP : model_sum(p, n, 6);
            exp_t = model_trit(exp_s, hi, lo);
            for (int i = 0; i < 4; i++) begin
                int k = 0;
                bus6.pos_cnt = 5'(p[i]); bus6.neg_cnt = 5'(n[i]); bus6.in_valid = 1'b1;
                while (!bus6.in_ready && k < 20) begin @(posedge clk); #1; k++; end
                @(posedge clk); #1;
                bus6.in_valid = 1'b0;
            end
            got = bus6.out_sum;
            n_cmp++; if (bus6.out_valid !== 1'b1 || got != exp_s || bus6.out_trit !== exp_t) begin
                n_err++; $display("FAIL w6_result t=%0d got=%0b/%0d/%b exp=1/%0d/%b", t, bus6.out_valid, got, bus6.out_trit, exp_s, exp_t);
            end
            bus6.out_ready = 1'b1;
            @(posedge clk); #1;
            bus6.out_ready = 1'b0;
        end
    endtask

    task automatic test_nbeats1();
        int p, n, exp_s, got, hi, lo;
        logic [1:0] exp_t;
        for (int t = 0; t < 12; t++) begin
            int k = 0;
            p = $urandom_range(0, 31); n = $urandom_range(0, 31);
            hi = int'($urandom_range(0, 30)) - 15;
            lo = int'($urandom_range(0, 30)) - 15;
            bus1.thr_hi = 8'(hi); bus1.thr_lo = 8'(lo);
            exp_s = upd(p - n, 8);
            exp_t = model_trit(exp_s, hi, lo);
            bus1.pos_cnt = 5'(p); bus1.neg_cnt = 5'(n); bus1.in_valid = 1'b1;
            while (!bus1.in_ready && k < 20) begin @(posedge clk); #1; k++; end
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            got = bus1.out_sum;
            n_cmp++; if (bus1.out_valid !== 1'b1 || got != exp_s || bus1.out_trit !== exp_t) begin
                n_err++; $display("FAIL nb1_result t=%0d got=%0b/%0d/%b exp=1/%0d/%b", t, bus1.out_valid, got, bus1.out_trit, exp_s, exp_t);
            end
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0; bus.out_ready  = 1'b0; bus.pos_cnt  = '0; bus.neg_cnt  = '0;
        bus.thr_hi    = '0;   bus.thr_lo     = '0;
        bus6.in_valid = 1'b0; bus6.out_ready = 1'b0; bus6.pos_cnt = '0; bus6.neg_cnt = '0;
        bus6.thr_hi   = '0;   bus6.thr_lo    = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.pos_cnt = '0; bus1.neg_cnt = '0;
        bus1.thr_hi   = '0;   bus1.thr_lo    = '0;
        @(posedge clk); #1;
        test_reset();
        test_directed_sum();
        test_negative_full();
        test_backpressure();
        test_reset_mid();
        test_priority_and_gaps();
        test_random();
        test_width6();
        test_nbeats1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
